atomrvcore_mdu: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations for the atomRVCORE execute stage, alongside the single-cycle ALU. It accepts one operation through a valid/ready handshake and computes it over DATAWIDTH iterations with a shift-add multiplier and a restoring divider. It returns the result through a second valid/ready handshake and supports a pipeline kill.

---
 rtl/atomrvcore_mdu_pkg.sv | 37 +++
 rtl/atomrvcore_mdu_negate.sv | 23 ++
 rtl/atomrvcore_mdu.sv | 186 ++++++++++++++++++
 tb/tb_atomrvcore_mdu.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atomrvcore_mdu_pkg.sv
// Shared definitions for the atomRVCORE multiply/divide unit: opcodes, FSM states
// and the operation classes latched at accept.
package atomrvcore_mdu_pkg;

    localparam int MDU_DATAWIDTH    = 32;
    localparam int MDU_OPCODE_WIDTH = 6;

    // RV32M opcodes, placed in the ALU opcode space
    localparam logic [5:0] OP_MUL    = 6'b010_010;
    localparam logic [5:0] OP_MULH   = 6'b010_011;
    localparam logic [5:0] OP_MULHSU = 6'b010_100;
    localparam logic [5:0] OP_MULHU  = 6'b010_101;
    localparam logic [5:0] OP_DIV    = 6'b010_110;
    localparam logic [5:0] OP_DIVU   = 6'b010_111;
    localparam logic [5:0] OP_REM    = 6'b011_000;
    localparam logic [5:0] OP_REMU   = 6'b011_001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    // Which half / which divide output ends up in the result
    typedef enum logic [1:0] {
        KIND_MUL_LO,
        KIND_MUL_HI,
        KIND_QUOT,
        KIND_REM
    } mdu_kind_e;

    function automatic logic is_div_kind(input mdu_kind_e kind);
        return (kind == KIND_QUOT) || (kind == KIND_REM);
    endfunction

endpackage

// File: rtl/atomrvcore_mdu_negate.sv
// Conditional two's-complement: bit i flips when negating and any lower bit is set.
module atomrvcore_mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_seen;

    assign w_seen[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_seen
            assign w_seen[gi+1] = w_seen[gi] | i_data[gi];
        end
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
            assign o_data[gi] = i_data[gi] ^ (i_neg & w_seen[gi]);
        end
    endgenerate

endmodule

// File: rtl/atomrvcore_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one accumulator, with valid/ready handshakes on both sides and a kill input.
module atomrvcore_mdu
    import atomrvcore_mdu_pkg::*;
#(
    parameter int DATAWIDTH    = MDU_DATAWIDTH,
    parameter int OPCODE_WIDTH = MDU_OPCODE_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    kill_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [OPCODE_WIDTH-1:0] ALUop_i,
    input  logic [DATAWIDTH-1:0]    operand_A,
    input  logic [DATAWIDTH-1:0]    operand_B,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATAWIDTH-1:0]    result_o
);

    localparam int DW = DATAWIDTH;
    localparam int CW = $clog2(DATAWIDTH) + 1;
    localparam int AW = 2 * DATAWIDTH + 1;
    localparam logic [DW-1:0] MIN_VAL  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] LAST_ITR = CW'(DATAWIDTH - 1);

    mdu_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_acc;
    logic [DW-1:0]     r_opnd;
    mdu_kind_e         r_kind;
    logic              r_res_neg;
    logic [DW-1:0]     r_result;

    // ---------------- request decode ----------------
    mdu_kind_e         w_kind;
    logic              w_known;
    logic              w_a_signed;
    logic              w_b_signed;

    always_comb begin
        w_kind     = KIND_MUL_LO;
        w_known    = 1'b1;
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (ALUop_i)
            OPCODE_WIDTH'(OP_MUL):    w_kind = KIND_MUL_LO;
            OPCODE_WIDTH'(OP_MULH):   begin w_kind = KIND_MUL_HI; w_a_signed = 1'b1; w_b_signed = 1'b1; end
            OPCODE_WIDTH'(OP_MULHSU): begin w_kind = KIND_MUL_HI; w_a_signed = 1'b1; end
            OPCODE_WIDTH'(OP_MULHU):  w_kind = KIND_MUL_HI;
            OPCODE_WIDTH'(OP_DIV):    begin w_kind = KIND_QUOT; w_a_signed = 1'b1; w_b_signed = 1'b1; end
            OPCODE_WIDTH'(OP_DIVU):   w_kind = KIND_QUOT;
            OPCODE_WIDTH'(OP_REM):    begin w_kind = KIND_REM; w_a_signed = 1'b1; w_b_signed = 1'b1; end
            OPCODE_WIDTH'(OP_REMU):   w_kind = KIND_REM;
            default:                  w_known = 1'b0;
        endcase
    end

    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_is_div;
    logic              w_res_neg;
    logic              w_b_zero;
    logic              w_ovf;
    logic [DW-1:0]     w_a_mag;
    logic [DW-1:0]     w_b_mag;

    assign w_a_neg   = w_a_signed & operand_A[DW-1];
    assign w_b_neg   = w_b_signed & operand_B[DW-1];
    assign w_is_div  = is_div_kind(w_kind);
    // Remainder follows the dividend; product and quotient follow the sign product
    assign w_res_neg = (w_kind == KIND_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_b_zero  = (operand_B == '0);
    assign w_ovf     = w_a_signed & (operand_A == MIN_VAL) & (&operand_B);

    atomrvcore_mdu_negate #(.WIDTH(DW)) u_neg_a (
        .i_neg  (w_a_neg),
        .i_data (operand_A),
        .o_data (w_a_mag)
    );

    atomrvcore_mdu_negate #(.WIDTH(DW)) u_neg_b (
        .i_neg  (w_b_neg),
        .i_data (operand_B),
        .o_data (w_b_mag)
    );

    // ---------------- iteration datapath ----------------
    logic [DW:0]       w_mul_sum;
    logic [AW-1:0]     w_mul_next;
    logic [DW:0]       w_rem_sh;
    logic [DW+1:0]     w_diff;
    logic              w_borrow;
    logic [AW-1:0]     w_div_next;

    // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {1'b0, w_mul_sum, r_acc[DW-1:1]};

    // Divide: shift the next dividend bit into the partial remainder and try the subtract
    assign w_rem_sh   = {r_acc[2*DW-1:DW], r_acc[DW-1]};
    assign w_diff     = {r_acc[AW-1], w_rem_sh} - {2'b00, r_opnd};
    assign w_borrow   = w_diff[DW+1];
    assign w_div_next = {(w_borrow ? w_rem_sh : w_diff[DW:0]), r_acc[DW-2:0], ~w_borrow};

    // ---------------- sign fix-up ----------------
    logic [2*DW-1:0]   w_fix_in;
    logic [2*DW-1:0]   w_fix_out;
    logic [DW-1:0]     w_fix_result;

    always_comb begin
        w_fix_in = r_acc[2*DW-1:0];
        if (r_kind == KIND_QUOT)
            w_fix_in = {{DW{1'b0}}, r_acc[DW-1:0]};
        else if (r_kind == KIND_REM)
            w_fix_in = {{DW{1'b0}}, r_acc[2*DW-1:DW]};
    end

    atomrvcore_mdu_negate #(.WIDTH(2 * DW)) u_neg_fix (
        .i_neg  (r_res_neg),
        .i_data (w_fix_in),
        .o_data (w_fix_out)
    );

    assign w_fix_result = (r_kind == KIND_MUL_HI) ? w_fix_out[2*DW-1:DW] : w_fix_out[DW-1:0];

    // ---------------- control ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_kind    <= KIND_MUL_LO;
            r_res_neg <= 1'b0;
            r_result  <= '0;
        end else if (kill_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_cnt     <= '0;
                        r_kind    <= w_kind;
                        r_res_neg <= w_res_neg;
                        r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
                        r_acc     <= {{(DW+1){1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        if (!w_known) begin
                            r_result <= '0;
                            r_state  <= ST_DONE;
                        end else if (w_is_div && w_b_zero) begin
                            r_result <= (w_kind == KIND_REM) ? operand_A : '1;
                            r_state  <= ST_DONE;
                        end else if (w_is_div && w_ovf) begin
                            r_result <= (w_kind == KIND_REM) ? '0 : MIN_VAL;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= is_div_kind(r_kind) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITR)
                        r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_result <= w_fix_result;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready_i)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (r_state == ST_IDLE);
    assign out_valid_o = (r_state == ST_DONE);
    assign result_o    = out_valid_o ? r_result : '0;

endmodule

// File: tb/tb_atomrvcore_mdu.sv
// Self-checking bench for atomrvcore_mdu: directed RV32M cases, randomized operations
// against a 64-bit arithmetic reference, back-pressure, kill and mid-operation reset.
module tb_atomrvcore_mdu;

    localparam logic [5:0] T_MUL    = 6'b010_010;
    localparam logic [5:0] T_MULH   = 6'b010_011;
    localparam logic [5:0] T_MULHSU = 6'b010_100;
    localparam logic [5:0] T_MULHU  = 6'b010_101;
    localparam logic [5:0] T_DIV    = 6'b010_110;
    localparam logic [5:0] T_DIVU   = 6'b010_111;
    localparam logic [5:0] T_REM    = 6'b011_000;
    localparam logic [5:0] T_REMU   = 6'b011_001;
    localparam logic [5:0] T_BAD    = 6'b111_111;
    localparam logic [31:0] MINV    = 32'h8000_0000;
    // Edges from the accepting edge (inclusive) to the first edge after which out_valid_o is high
    localparam int LAT_NORMAL = 34;
    localparam int LAT_FAST   = 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        kill_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [5:0]  ALUop_i = '0;
    logic [31:0] operand_A = '0;
    logic [31:0] operand_B = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    atomrvcore_mdu dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .kill_i      (kill_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .ALUop_i     (ALUop_i),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic signed [31:0] q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            T_MUL:    begin up = ua * ub; return up[31:0]; end
            T_MULH:   begin sp = sa * sb; return sp[63:32]; end
            T_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
            T_MULHU:  begin up = ua * ub; return up[63:32]; end
            T_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                q = $signed(a) / $signed(b);
                return q;
            end
            T_REM: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                r = $signed(a) % $signed(b);
                return r;
            end
            T_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            T_REMU: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic is_div, is_sdiv;
        is_div  = (op == T_DIV) || (op == T_DIVU) || (op == T_REM) || (op == T_REMU);
        is_sdiv = (op == T_DIV) || (op == T_REM);
        if (!(is_div || op == T_MUL || op == T_MULH || op == T_MULHSU || op == T_MULHU)) return LAT_FAST;
        if (is_div && b == 0) return LAT_FAST;
        if (is_sdiv && a == MINV && b == 32'hFFFF_FFFF) return LAT_FAST;
        return LAT_NORMAL;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Returns #1 after the accepting edge, with the request already withdrawn and operands scrambled
    task automatic do_accept(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
        int guard;
        guard = 0;
        while (!in_ready_o && guard < 100) begin
            @(posedge clk_i); #1;
            guard++;
        end
        ok = in_ready_o;
        in_valid_i = 1'b1;
        ALUop_i    = op;
        operand_A  = a;
        operand_B  = b;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        ALUop_i    = 6'($urandom);
        operand_A  = $urandom;
        operand_B  = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic take_result();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    // Full transaction with result, latency and post-transfer checks
    task automatic run_checked(input string name, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        int lat;
        logic [31:0] exp_r;
        int exp_l;
        exp_r = ref_result(op, a, b);
        exp_l = ref_latency(op, a, b);
        do_accept(op, a, b, ok);
        n_vec++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept: in_ready_o=%b required 1", name, in_ready_o);
        end
        wait_valid(lat);
        $display("txn %s op=%b a=%h b=%h result=%h lat=%0d", name, op, a, b, result_o, lat);
        n_vec++;
        if (result_o !== exp_r) begin
            n_err++;
            $display("FAIL %s result: got %h required %h", name, result_o, exp_r);
        end
        n_vec++;
        if (lat !== exp_l) begin
            n_err++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_l);
        end
        take_result();
        n_vec++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 32'd0) begin
            n_err++;
            $display("FAIL %s release: ready=%b valid=%b result=%h required 1 0 0", name, in_ready_o, out_valid_o, result_o);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        $display("txn reset ready=%b valid=%b result=%h", in_ready_o, out_valid_o, result_o);
        n_vec++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h required 1 0 00000000", in_ready_o, out_valid_o, result_o);
        end
    endtask

    task automatic test_directed();
        run_checked("mul_7xm3",    T_MUL,   32'd7,          32'hFFFF_FFFD);
        run_checked("mulh_min",    T_MULH,  MINV,           MINV);
        run_checked("mulhu_max",   T_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_checked("div_m7_2",    T_DIV,   32'hFFFF_FFF9,  32'd2);
        run_checked("rem_m7_2",    T_REM,   32'hFFFF_FFF9,  32'd2);
        run_checked("divu_100_7",  T_DIVU,  32'd100,        32'd7);
        run_checked("remu_100_7",  T_REMU,  32'd100,        32'd7);
        run_checked("divu_by0",    T_DIVU,  32'd5,          32'd0);
        run_checked("remu_by0",    T_REMU,  32'd5,          32'd0);
        run_checked("div_ovf",     T_DIV,   MINV,           32'hFFFF_FFFF);
        run_checked("rem_ovf",     T_REM,   MINV,           32'hFFFF_FFFF);
        run_checked("mulhsu_mix",  T_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_checked("bad_opcode",  T_BAD,   32'h1234_5678,  32'h9ABC_DEF0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return MINV;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [5:0] ops [9];
        ops = '{T_MUL, T_MULH, T_MULHSU, T_MULHU, T_DIV, T_DIVU, T_REM, T_REMU, T_BAD};
        for (int i = 0; i < 40; i++) begin
            run_checked($sformatf("rand%0d", i), ops[$urandom_range(0, 8)], pick_operand(), pick_operand());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        logic [31:0] exp_r;
        exp_r = ref_result(T_DIVU, 32'd1000, 32'd9);
        do_accept(T_DIVU, 32'd1000, 32'd9, ok);
        wait_valid(lat);
        n_vec++;
        if (out_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_valid: got %b required 1", out_valid_o);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            n_vec++;
            if (out_valid_o !== 1'b1 || result_o !== exp_r || in_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b result=%h ready=%b required 1 %h 0", c, out_valid_o, result_o, in_ready_o, exp_r);
            end
        end
        $display("txn backpressure held result=%h", result_o);
        take_result();
        n_vec++;
        if (in_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_after: got %b required 1", in_ready_o);
        end
        // Request right away: the edge one cycle after the transfer must accept it
        in_valid_i = 1'b1; ALUop_i = T_MUL; operand_A = 32'd3; operand_B = 32'd4;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        n_vec++;
        if (in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_next_accept: in_ready_o=%b required 0", in_ready_o);
        end
        wait_valid(lat);
        $display("txn back_to_back mul result=%h lat=%0d", result_o, lat);
        n_vec++;
        if (result_o !== 32'd12 || lat !== LAT_NORMAL) begin
            n_err++;
            $display("FAIL bp_next_result: got %h lat %0d required 0000000c lat %0d", result_o, lat, LAT_NORMAL);
        end
        take_result();
    endtask

    task automatic test_kill();
        bit ok;
        bit saw;
        do_accept(T_MUL, $urandom, $urandom, ok);
        repeat (9) @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        n_vec++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL kill_calc: ready=%b valid=%b required 1 0", in_ready_o, out_valid_o);
        end
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i); #1;
            if (out_valid_o) saw = 1'b1;
        end
        $display("txn kill_in_calc later_valid=%b", saw);
        n_vec++;
        if (saw !== 1'b0) begin
            n_err++;
            $display("FAIL kill_no_pulse: saw out_valid_o=%b required 0", saw);
        end
        run_checked("after_kill_mul", T_MUL, 32'd3, 32'd4);

        // Kill a pending fast-path result in DONE
        do_accept(T_DIVU, 32'd5, 32'd0, ok);
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        $display("txn kill_in_done valid=%b result=%h", out_valid_o, result_o);
        n_vec++;
        if (out_valid_o !== 1'b0 || result_o !== 32'd0 || in_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL kill_done: valid=%b result=%h ready=%b required 0 0 1", out_valid_o, result_o, in_ready_o);
        end

        // Kill in IDLE blocks the request
        in_valid_i = 1'b1; kill_i = 1'b1; ALUop_i = T_MUL; operand_A = 32'd2; operand_B = 32'd2;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; kill_i = 1'b0;
        $display("txn kill_in_idle ready=%b", in_ready_o);
        n_vec++;
        if (in_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL kill_idle_reject: in_ready_o=%b required 1", in_ready_o);
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        bit saw;
        do_accept(T_MULHU, $urandom, $urandom, ok);
        repeat (32) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_vec++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 32'd0) begin
            n_err++;
            $display("FAIL rst_in_fix: ready=%b valid=%b result=%h required 1 0 0", in_ready_o, out_valid_o, result_o);
        end
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            if (out_valid_o) saw = 1'b1;
        end
        $display("txn reset_in_fix later_valid=%b", saw);
        n_vec++;
        if (saw !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fix_no_pulse: saw out_valid_o=%b required 0", saw);
        end

        do_accept(T_REMU, 32'd77, 32'd0, ok);
        rst_i = 1'b1; kill_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; kill_i = 1'b0;
        $display("txn reset_in_done valid=%b result=%h", out_valid_o, result_o);
        n_vec++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 32'd0) begin
            n_err++;
            $display("FAIL rst_in_done: ready=%b valid=%b result=%h required 1 0 0", in_ready_o, out_valid_o, result_o);
        end
        run_checked("after_reset_div", T_DIV, 32'hFFFF_FF9C, 32'd7);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_kill();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
